acc_cpu_core: RTL and testbench



---
 rtl/acc_cpu_core.sv | 108 ++++++++++
 tb/tb_acc_cpu_core.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: multicycle accumulator CPU with a req/ready single-port memory interface
module acc_cpu_core #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 28,
    parameter int unsigned PC_RESET   = 'h100,
    parameter int unsigned PC_STEP    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] ac_out,
    output logic                  halted,
    output logic                  retire
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(PC_RESET);
    localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(PC_STEP);
    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_ac;
    logic [DATA_WIDTH-1:0] r_ir;
    logic                  w_imm;
    logic                  w_is_mem;
    logic                  w_store;
    logic                  w_halt;
    logic                  w_jump;
    logic                  w_cond;
    logic                  w_skip;
    logic [3:0]            w_op;
    logic [DATA_WIDTH-6:0] w_opnd;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_b;
    logic [DATA_WIDTH-1:0] w_alu;
    assign w_imm    = r_ir[DATA_WIDTH-1];
    assign w_op     = r_ir[DATA_WIDTH-2 -: 4];
    assign w_opnd   = r_ir[DATA_WIDTH-6:0];
    assign w_addr   = ADDR_WIDTH'(w_opnd);
    assign w_is_mem = !w_imm && (w_op inside {4'd0, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9});
    assign w_store  = w_op == 4'd3;
    assign w_halt   = !w_imm && w_op == 4'd1;
    assign w_jump   = !w_imm && w_op == 4'd6;
    assign w_cond   = r_ir[11] ? (!r_ir[10] && !r_ac[DATA_WIDTH-1] && |r_ac)
                               : (r_ir[10] ? ~|r_ac : r_ac[DATA_WIDTH-1]);
    assign w_skip   = !w_imm && w_op == 4'd5 && w_cond;
    assign w_b      = r_state == S_MEM ? mem_rdata : DATA_WIDTH'(w_opnd);
    always_comb begin
        case (w_op)
            4'd0:    w_alu = r_ac + w_b;
            4'd2:    w_alu = w_imm ? r_ac : w_b;
            4'd4:    w_alu = w_imm ? r_ac : '0;
            4'd7:    w_alu = r_ac - w_b;
            4'd8:    w_alu = r_ac & w_b;
            4'd9:    w_alu = r_ac | w_b;
            4'd10:   w_alu = w_imm ? r_ac : ~r_ac;
            default: w_alu = r_ac;
        endcase
    end
    assign mem_req   = r_state == S_FETCH || r_state == S_MEM;
    assign mem_we    = r_state == S_MEM && w_store;
    assign mem_addr  = r_state == S_FETCH ? r_pc : (r_state == S_MEM ? w_addr : '0);
    assign mem_wdata = mem_we ? r_ac : '0;
    assign pc_out    = r_pc;
    assign ac_out    = r_ac;
    assign halted    = r_state == S_HALT;
    assign retire    = r_state == S_EXEC || (r_state == S_MEM && mem_ready);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= PC_INIT;
            r_ac    <= '0;
            r_ir    <= '0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: if (mem_ready) begin
                    r_ir    <= mem_rdata;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_pc    <= r_pc + STEP;
                    r_state <= w_is_mem ? S_MEM : S_EXEC;
                end
                S_EXEC: begin
                    r_ac    <= w_alu;
                    r_pc    <= w_jump ? w_addr : (w_skip ? r_pc + STEP : r_pc);
                    r_state <= w_halt ? S_HALT : S_FETCH;
                end
                S_MEM: if (mem_ready) begin
                    r_ac    <= w_alu;
                    r_state <= S_FETCH;
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_cpu_core.sv
// tb_acc_cpu_core: ISA-level reference model plus directed programs for acc_cpu_core
module tb_acc_cpu_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready = 1'b0, halted, retire;
    logic [27:0] mem_addr, pc_out;
    logic [31:0] mem_wdata, mem_rdata = '0, ac_out;
    logic        s_rst = 1'b1, s_req, s_we, s_ready = 1'b1, s_halted, s_retire;
    logic [7:0]  s_addr, s_pc;
    logic [15:0] s_wdata, s_rdata = '0, s_ac;

    acc_cpu_core dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_out(pc_out), .ac_out(ac_out), .halted(halted), .retire(retire)
    );

    acc_cpu_core #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .PC_RESET('h10), .PC_STEP(2)) dut16 (
        .clk(clk), .rst(s_rst), .mem_req(s_req), .mem_we(s_we), .mem_addr(s_addr),
        .mem_wdata(s_wdata), .mem_rdata(s_rdata), .mem_ready(s_ready),
        .pc_out(s_pc), .ac_out(s_ac), .halted(s_halted), .retire(s_retire)
    );

    initial forever #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, waitn = 0, wcnt = 0;
    logic rst_at_edge = 1'b0;
    logic [31:0] tb_mem [0:511];
    logic [31:0] m_mem  [0:511];
    logic [15:0] s_mem  [0:255];
    logic [27:0] m_pc;
    logic [31:0] m_ac;
    logic        m_halt;
    int          n_ret = 0, t_start = 0;
    logic [31:0] hist_ac [0:31];
    logic [27:0] hist_pc [0:31];
    int          lat [0:31];
    int          s_nret = 0;
    logic        s_after = 1'b0;
    logic [7:0]  s_hist_pc [0:15];
    logic [15:0] s_hist_ac [0:15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load_prog_a();
        for (int i = 0; i < 512; i++) tb_mem[i] = '0;
        tb_mem['h100] = 32'h1000011E;
        tb_mem['h102] = 32'h00000120;
        tb_mem['h104] = 32'h1800011C;
        tb_mem['h106] = 32'h08000000;
        tb_mem['h11E] = 32'd5;
        tb_mem['h120] = 32'd7;
        m_mem = tb_mem;
    endtask

    task automatic load_prog_b();
        for (int i = 0; i < 512; i++) tb_mem[i] = '0;
        tb_mem['h100] = 32'h20000000;
        tb_mem['h102] = 32'hB8000001;
        tb_mem['h104] = 32'h28000400;
        tb_mem['h106] = 32'h28000000;
        tb_mem['h108] = 32'h08000000;
        tb_mem['h10A] = 32'h50000000;
        tb_mem['h10C] = 32'hC8000F0F;
        tb_mem['h10E] = 32'hC00000FF;
        tb_mem['h110] = 32'h48000120;
        tb_mem['h112] = 32'h4000011E;
        tb_mem['h114] = 32'h38000120;
        tb_mem['h116] = 32'h28000800;
        tb_mem['h118] = 32'h28000C00;
        tb_mem['h11A] = 32'h88000000;
        tb_mem['h11C] = 32'h30000100;
        tb_mem['h11E] = 32'd5;
        tb_mem['h120] = 32'd7;
        m_mem = tb_mem;
    endtask

    task automatic restart(input int wn, input bit prog_b);
        @(posedge clk); #1 rst = 1'b1; waitn = wn;
        @(posedge clk); #1;
        if (prog_b) load_prog_b(); else load_prog_a();
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic run_until_halt(input int limit);
        int k = 0;
        while (!halted && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("halt_reached", halted, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_retires(input int n, input int limit);
        int k = 0;
        while (n_ret < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("retires_reached", n_ret >= n, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_prog_a(input string tag);
        check({tag, "_store"}, tb_mem['h11C], 32'd12);
        check({tag, "_ac"}, ac_out, 32'd12);
        check({tag, "_pc"}, pc_out, 28'h108);
        check({tag, "_halted"}, halted, 1);
        check({tag, "_retires"}, n_ret, 4);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        rst_at_edge = rst;
    end

    // memory responder: waitn stall cycles per access, ready with junk data while idle
    initial forever begin
        @(posedge clk); #1;
        if (!mem_req) begin
            mem_ready = 1'b1;
            mem_rdata = 32'hDEADBEEF;
            wcnt = 0;
        end else if (wcnt >= waitn) begin
            mem_ready = 1'b1;
            mem_rdata = tb_mem[mem_addr[8:0]];
            if (mem_we) tb_mem[mem_addr[8:0]] = mem_wdata;
            wcnt = 0;
        end else begin
            mem_ready = 1'b0;
            mem_rdata = 32'hDEADBEEF;
            wcnt++;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        s_rdata = s_mem[s_addr];
    end

    initial forever begin
        @(negedge clk);
        if (s_after) begin
            s_hist_pc[s_nret] = s_pc;
            s_hist_ac[s_nret] = s_ac;
        end
        s_after = 1'b0;
        if (s_retire && s_nret < 15) begin
            s_nret++;
            s_after = 1'b1;
        end
    end

    initial begin : cmp
        logic        after_ret, expect_fetch, prev_pend, prev_we, imm, is_mem, taken;
        logic [27:0] prev_addr, a;
        logic [31:0] prev_wdata, ir, opv, mv;
        logic [3:0]  op;
        after_ret = 0; expect_fetch = 0; prev_pend = 0;
        m_pc = 28'h100; m_ac = '0; m_halt = 0;
        forever begin
            @(negedge clk);
            if (rst_at_edge) begin
                m_pc = 28'h100; m_ac = '0; m_halt = 0;
                n_ret = 0; t_start = cyc;
                after_ret = 0; expect_fetch = 1; prev_pend = 0;
                check("rst_req", mem_req, 0);
                check("rst_we", mem_we, 0);
                check("rst_addr", mem_addr, 0);
                check("rst_wdata", mem_wdata, 0);
                check("rst_pc", pc_out, 28'h100);
                check("rst_ac", ac_out, 0);
                check("rst_halted", halted, 0);
                check("rst_retire", retire, 0);
            end else begin
                if (after_ret) begin
                    if (n_ret < 32) begin
                        hist_pc[n_ret] = pc_out;
                        hist_ac[n_ret] = ac_out;
                    end
                    check("pc_after_retire", pc_out, m_pc);
                end
                after_ret = 0;
                check("ac", ac_out, m_ac);
                check("halted", halted, m_halt);
                if (expect_fetch) begin
                    check("fetch_req", mem_req, 1);
                    check("fetch_we", mem_we, 0);
                    check("fetch_addr", mem_addr, m_pc);
                end
                expect_fetch = 0;
                if (prev_pend) begin
                    check("hold_req", mem_req, 1);
                    check("hold_we", mem_we, prev_we);
                    check("hold_addr", mem_addr, prev_addr);
                    check("hold_wdata", mem_wdata, prev_wdata);
                end
                if (!mem_req) begin
                    check("idle_addr", mem_addr, 0);
                    check("idle_wdata", mem_wdata, 0);
                end else if (!mem_we) begin
                    check("read_wdata", mem_wdata, 0);
                end
                if (m_halt) begin
                    check("halt_req", mem_req, 0);
                    check("halt_retire", retire, 0);
                end
                prev_pend = mem_req && !mem_ready;
                prev_we = mem_we; prev_addr = mem_addr; prev_wdata = mem_wdata;
                if (retire && !m_halt) begin
                    ir = m_mem[m_pc[8:0]];
                    imm = ir[31]; op = ir[30:27];
                    opv = {5'b0, ir[26:0]};
                    a = {1'b0, ir[26:0]};
                    mv = m_mem[a[8:0]];
                    is_mem = !imm && (op inside {4'd0, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9});
                    m_pc = m_pc + 28'd2;
                    if (!imm) begin
                        case (op)
                            4'd0: m_ac = m_ac + mv;
                            4'd1: m_halt = 1;
                            4'd2: m_ac = mv;
                            4'd3: m_mem[a[8:0]] = m_ac;
                            4'd4: m_ac = '0;
                            4'd5: begin
                                taken = (ir[11:10] == 2'd0 && $signed(m_ac) < 0) ||
                                        (ir[11:10] == 2'd1 && m_ac == 0) ||
                                        (ir[11:10] == 2'd2 && $signed(m_ac) > 0);
                                if (taken) m_pc = m_pc + 28'd2;
                            end
                            4'd6: m_pc = a;
                            4'd7: m_ac = m_ac - mv;
                            4'd8: m_ac = m_ac & mv;
                            4'd9: m_ac = m_ac | mv;
                            4'd10: m_ac = ~m_ac;
                            default: ;
                        endcase
                    end else begin
                        case (op)
                            4'd0: m_ac = m_ac + opv;
                            4'd7: m_ac = m_ac - opv;
                            4'd8: m_ac = m_ac & opv;
                            4'd9: m_ac = m_ac | opv;
                            default: ;
                        endcase
                    end
                    check("latency", cyc - t_start, is_mem ? 3 + 2 * waitn : 3 + waitn);
                    n_ret++;
                    if (n_ret < 32) lat[n_ret] = cyc - t_start;
                    t_start = cyc;
                    after_ret = 1;
                    expect_fetch = !m_halt;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < 256; i++) s_mem[i] = '0;
        s_mem['h10] = 16'h5000;
        s_mem['h12] = 16'h87FF;
        s_mem['h14] = 16'h31F0;
        s_mem['hF0] = 16'h30FE;
        s_mem['hFE] = 16'h5800;
        s_mem['h00] = 16'h0800;
        rst = 1'b1;
        waitn = 0;
        load_prog_a();
        repeat (3) @(negedge clk);
        check("reset_pc", pc_out, 28'h100);
        check("reset_req", mem_req, 0);
        check("reset_ac", ac_out, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_cycle_req", mem_req, 0);
        @(negedge clk);
        check("first_req", mem_req, 1);
        check("first_addr", mem_addr, 28'h100);
        run_until_halt(200);
        check_prog_a("zw");
        check("zw_lat_load", lat[1], 3);
        k = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_req) k++;
        end
        check("no_req_after_halt", k, 0);

        restart(3, 1'b0);
        run_until_halt(400);
        check_prog_a("ws");
        check("ws_lat_load", lat[1], 9);
        check("ws_lat_store", lat[3], 9);
        check("ws_lat_halt", lat[4], 6);

        restart(1, 1'b1);
        wait_retires(16, 800);
        check("b_subi", hist_ac[2], 32'hFFFFFFFF);
        check("b_skipz_not_taken", hist_pc[3], 28'h106);
        check("b_skipn_taken", hist_pc[4], 28'h10A);
        check("b_not", hist_ac[5], 32'h0);
        check("b_ori", hist_ac[6], 32'h00000F0F);
        check("b_andi", hist_ac[7], 32'h0000000F);
        check("b_or", hist_ac[8], 32'h0000000F);
        check("b_and", hist_ac[9], 32'h5);
        check("b_sub", hist_ac[10], 32'hFFFFFFFE);
        check("b_skipp_not_taken", hist_pc[11], 28'h118);
        check("b_never", hist_pc[12], 28'h11A);
        check("b_jump", hist_pc[14], 28'h100);
        check("b_lat_skip", lat[4], 4);

        restart(3, 1'b0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(mem_req && mem_addr == 28'h120) && k < 200);
        check("abort_found", mem_req && mem_addr == 28'h120, 1);
        check("abort_pre_ac", ac_out, 32'd5);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_req", mem_req, 0);
        check("abort_ac", ac_out, 0);
        check("abort_pc", pc_out, 28'h100);
        @(negedge clk);
        check("abort_refetch", mem_addr, 28'h100);
        run_until_halt(400);
        check_prog_a("ab");

        @(posedge clk); #1 s_rst = 1'b0;
        k = 0;
        while (!s_halted && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check("w16_halted", s_halted, 1);
        check("w16_retires", s_nret, 6);
        check("w16_not", s_hist_ac[1], 16'hFFFF);
        check("w16_addi_wrap", s_hist_ac[2], 16'h07FE);
        check("w16_jump_trunc", s_hist_pc[3], 8'hF0);
        check("w16_jump_fe", s_hist_pc[4], 8'hFE);
        check("w16_pc_wrap", s_hist_pc[5], 8'h00);
        check("w16_final_pc", s_pc, 8'h02);
        check("w16_final_ac", s_ac, 16'h07FE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
